// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared types and defaults for the BPSK symbol RAM arbiter
//
// Contents:
//   arb_state_t     : arbiter FSM states (ARB, DRAIN, LOCKED)
//   *_DEF constants : default address/data widths, read latency, write wait limit

package bpsk_pkg;

   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 8;
   localparam int RD_LATENCY_DEF = 2;
   localparam int MAX_WAIT_DEF   = 15;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      DRAIN  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bpsk_ram_arbiter_rd_valid_pipe.sv
// rtl/bpsk_ram_arbiter_rd_valid_pipe.sv - read valid shift register with in-flight empty flag
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : a read command is on the RAM port this cycle
//   out_valid  : read data is on the RAM output this cycle
//   empty      : no read is on the RAM port or inside the pipeline

module rd_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic out_valid,
   output logic empty
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign out_valid = sr[DEPTH-1];
   // The command currently on the RAM port counts as in flight too.
   assign empty     = ~in_valid & ~(|sr);

endmodule

// File: rtl/bpsk_ram_arbiter.sv
// rtl/bpsk_ram_arbiter.sv - shares BPSK symbol BRAM port B between modulator reads and loader writes
//
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   rd_req/rd_addr/rd_gnt        : modulator read request (held until granted), combinational grant
//   rd_valid/rd_data             : one-cycle read return strobe and byte
//   wr_req/wr_addr/wr_data/wr_gnt: loader write request (held until granted), combinational grant
//   lock_req/lock_gnt            : loader exclusive burst request (level) and registered grant
//   ram_*                        : registered BRAM port B command, read data in, active-high reset

module bpsk_ram_arbiter
   import bpsk_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF,
   parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              lock_req,
   output logic              lock_gnt,
   output logic              ram_clk,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              ram_rst
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             forced;
   logic             fire_rd, fire_wr;
   logic             rd_issued;
   logic             pipe_valid, pipe_empty;

   assign ram_clk = clk;

   // A write refused MAX_WAIT times in a row wins the next cycle outright.
   assign forced = (wait_cnt == CNT_W'(MAX_WAIT));

   always_comb begin
      state_nxt    = state;
      rd_gnt       = 1'b0;
      wr_gnt       = 1'b0;
      wait_cnt_nxt = '0;
      case (state)
         ARB: begin
            rd_gnt = rd_req & ~forced;
            wr_gnt = forced ? wr_req : (wr_req & ~rd_req);
            if (wr_req && !wr_gnt) begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
            // Grants above still apply in the cycle lock_req rises.
            if (lock_req) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!lock_req) begin
               state_nxt = ARB;
            end else if (pipe_empty) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            wr_gnt = wr_req & lock_req;
            if (!lock_req) begin
               state_nxt = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   assign fire_rd   = rd_req & rd_gnt;
   assign fire_wr   = wr_req & wr_gnt;
   assign rd_issued = ram_en & ~ram_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ARB;
         wait_cnt    <= '0;
         lock_gnt    <= 1'b0;
         ram_rst     <= 1'b1;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wr_data <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         lock_gnt <= (state_nxt == LOCKED);
         ram_rst  <= 1'b0;
         ram_en   <= fire_rd | fire_wr;
         ram_we   <= fire_wr;
         if (fire_wr) begin
            ram_addr    <= wr_addr;
            ram_wr_data <= wr_data;
         end else if (fire_rd) begin
            ram_addr <= rd_addr;
         end
      end
   end

   rd_valid_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_rd_valid_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_issued),
      .out_valid (pipe_valid),
      .empty     (pipe_empty)
   );

   assign rd_valid = pipe_valid;
   assign rd_data  = pipe_valid ? ram_rd_data : '0;

endmodule

// File: tb/tb_bpsk_ram_arbiter.sv
// tb/tb_bpsk_ram_arbiter.sv - directed scoreboard bench for bpsk_ram_arbiter

module tb_bpsk_ram_arbiter;
   import bpsk_pkg::*;

   localparam int LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd_req, wr_req, lock_req;
   logic [7:0] rd_addr, wr_addr, wr_data;
   logic       rd_gnt, wr_gnt, rd_valid, lock_gnt;
   logic [7:0] rd_data;
   logic       ram_clk, ram_en, ram_we, ram_rst;
   logic [7:0] ram_addr, ram_wr_data, ram_rd_data;

   always #5 clk = ~clk;

   bpsk_ram_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_gnt      (rd_gnt),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_gnt      (wr_gnt),
      .lock_req    (lock_req),
      .lock_gnt    (lock_gnt),
      .ram_clk     (ram_clk),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_data (ram_rd_data),
      .ram_rst     (ram_rst)
   );

   function automatic logic [7:0] init_val(input int i);
      logic [7:0] v;
      v = 8'(i * 13 + 7);
      if (i == 5) v = 8'hA5;
      return v;
   endfunction

   // BRAM model with output register: data two cycles after the enable cycle.
   logic [7:0] ram_mem [256];
   logic [7:0] dout_a = 8'h00;
   logic       init_done = 1'b0;
   initial ram_rd_data = 8'h00;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
         init_done <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wr_data;
         dout_a <= ram_mem[ram_addr];
      end
      ram_rd_data <= dout_a;
   end

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       q[$];
   logic [7:0] exp_mem [256];
   int         tests = 0, fails = 0;
   int         cyc = 0, n_valid = 0, n_wgnt = 0;
   logic [7:0] last_rd = 8'h00;

   logic       s_rd_gnt, s_wr_gnt, s_rd_valid, s_lock_gnt, s_ram_en, s_ram_we, s_ram_rst;
   logic [7:0] s_rd_data, s_ram_addr, s_ram_wr_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, run the scoreboard, return just after the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      s_rd_gnt = rd_gnt;   s_wr_gnt = wr_gnt;     s_rd_valid = rd_valid;
      s_lock_gnt = lock_gnt; s_ram_en = ram_en;   s_ram_we = ram_we;
      s_ram_rst = ram_rst; s_rd_data = rd_data;   s_ram_addr = ram_addr;
      s_ram_wr_data = ram_wr_data;
      if (!rst_n) begin
         q.delete();
      end else begin
         chk("gnt_exclusive", 32'(s_rd_gnt & s_wr_gnt), 0);
         if (s_lock_gnt) chk("rd_gnt_while_locked", 32'(s_rd_gnt), 0);
         if (rd_req && s_rd_gnt) begin
            e.data = exp_mem[rd_addr];
            e.due  = cyc + LAT + 1;
            q.push_back(e);
         end
         if (wr_req && s_wr_gnt) begin
            exp_mem[wr_addr] = wr_data;
            n_wgnt++;
         end
         if (s_rd_valid) begin
            n_valid++;
            last_rd = s_rd_data;
            if (q.size() == 0) begin
               chk("rd_valid_unexpected", 1, 0);
            end else begin
               e = q.pop_front();
               chk("rd_data", 32'(s_rd_data), 32'(e.data));
               chk("rd_latency", cyc, e.due);
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("rd_valid_missing", 0, 1);
            void'(q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ram_en"}, 32'(s_ram_en), 0);
      chk({tag, "_ram_we"}, 32'(s_ram_we), 0);
      chk({tag, "_ram_addr"}, 32'(s_ram_addr), 0);
      chk({tag, "_ram_wr_data"}, 32'(s_ram_wr_data), 0);
      chk({tag, "_rd_valid"}, 32'(s_rd_valid), 0);
      chk({tag, "_rd_data"}, 32'(s_rd_data), 0);
      chk({tag, "_lock_gnt"}, 32'(s_lock_gnt), 0);
      chk({tag, "_ram_rst"}, 32'(s_ram_rst), 1);
   endtask

   initial begin
      int v0, w0, refused, granted, got;
      rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; lock_req = 1'b0;
      rd_addr = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;
      for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

      // Reset state
      repeat (3) tick();
      chk_reset("rst");
      rst_n = 1'b1;
      tick();
      tick();
      chk("ram_rst_release", 32'(s_ram_rst), 0);
      chk("idle_ram_en", 32'(s_ram_en), 0);
      repeat (4) tick();

      // Single read of 0x05
      rd_req = 1'b1; rd_addr = 8'h05;
      tick();
      chk("single_rd_gnt", 32'(s_rd_gnt), 1);
      rd_req = 1'b0;
      tick();
      chk("single_ram_en", 32'(s_ram_en), 1);
      chk("single_ram_addr", 32'(s_ram_addr), 32'h05);
      chk("single_ram_we", 32'(s_ram_we), 0);
      tick();
      chk("single_early_valid", 32'(s_rd_valid), 0);
      tick();
      chk("single_rd_valid", 32'(s_rd_valid), 1);
      chk("single_rd_data", 32'(s_rd_data), 32'hA5);
      tick();
      chk("single_one_cycle", 32'(s_rd_valid), 0);

      // Back-to-back reads 0x00-0x03
      v0 = n_valid;
      for (int i = 0; i < 4; i++) begin
         rd_req = 1'b1; rd_addr = 8'(i);
         tick();
         chk("b2b_rd_gnt", 32'(s_rd_gnt), 1);
      end
      rd_req = 1'b0;
      repeat (5) tick();
      chk("b2b_count", n_valid - v0, 4);

      // Write starvation guard under continuous reads
      w0 = n_wgnt; refused = 0; granted = 0;
      rd_req = 1'b1; rd_addr = 8'h00;
      wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'h3C;
      for (int k = 0; k < 40 && granted == 0; k++) begin
         tick();
         if (s_wr_gnt) begin
            granted = 1;
            chk("starve_rd_gnt_low", 32'(s_rd_gnt), 0);
         end else begin
            refused++;
         end
      end
      wr_req = 1'b0;
      chk("starve_granted", granted, 1);
      chk("starve_refused", refused, 15);
      rd_addr = 8'h10;
      repeat (3) tick();
      rd_req = 1'b0;
      repeat (5) tick();
      chk("starve_once", n_wgnt - w0, 1);
      chk("starve_readback", 32'(last_rd), 32'h3C);

      // Lock with drain: second read coincides with lock_req rising
      rd_req = 1'b1; rd_addr = 8'h01;
      tick();
      rd_addr = 8'h02; lock_req = 1'b1;
      tick();
      chk("lock_same_cycle_rd_gnt", 32'(s_rd_gnt), 1);
      rd_addr = 8'h03;
      v0 = n_valid; got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         tick();
         if (s_lock_gnt) got = 1;
         else chk("drain_rd_gnt", 32'(s_rd_gnt), 0);
      end
      chk("lock_gnt_rise", got, 1);
      chk("drain_strobes_before_lock", n_valid - v0, 2);
      chk("drain_pipe_empty", q.size(), 0);
      for (int i = 0; i < 8; i++) begin
         wr_req = 1'b1; wr_addr = 8'(8'h20 + i); wr_data = 8'(8'h50 + i);
         tick();
         chk("locked_wr_gnt", 32'(s_wr_gnt), 1);
         chk("locked_rd_gnt", 32'(s_rd_gnt), 0);
      end
      lock_req = 1'b0; wr_addr = 8'h30; wr_data = 8'hEE;
      tick();
      chk("unlock_no_wr", 32'(s_wr_gnt), 0);
      chk("unlock_no_rd", 32'(s_rd_gnt), 0);
      chk("unlock_lock_gnt_held", 32'(s_lock_gnt), 1);
      wr_req = 1'b0; rd_addr = 8'h23;
      tick();
      chk("resume_rd_gnt", 32'(s_rd_gnt), 1);
      chk("lock_gnt_cleared", 32'(s_lock_gnt), 0);
      rd_req = 1'b0;
      repeat (5) tick();
      chk("locked_wr_readback", 32'(last_rd), 32'h53);

      // Reset with a read in flight
      rd_req = 1'b1; rd_addr = 8'h05;
      tick();
      chk("midrst_rd_gnt", 32'(s_rd_gnt), 1);
      rd_req = 1'b0; rst_n = 1'b0;
      tick();
      tick();
      chk_reset("midrst");
      rst_n = 1'b1;
      v0 = n_valid;
      repeat (6) tick();
      chk("midrst_no_valid", n_valid - v0, 0);
      chk("scoreboard_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
